equal_comparator_four: RTL and testbench
========================================

// Module: equal_comparator_four
//
// PURPOSE
//   Registered 4-bit equality comparator. Samples two operands on a clock edge
//   and reports whether they are bit-for-bit identical.
//   Also provides the per-bit mismatch mask and a saturating mismatch counter
//   for datapath checking and self-test logic.
//   Sits between a producer of operand pairs and any consumer that needs a
//   clean, registered equal flag.
//
// PARAMETERS
//   WIDTH     4   operand width in bits; default matches the 4-bit use case
//   CNT_WIDTH 8   width of the saturating mismatch counter
//
// PORTS
//   clk           in   1          single clock; all state updates on rising edge
//   rst_n         in   1          asynchronous reset, active-low
//   in_valid      in   1          a/b qualify this cycle
//   a             in   WIDTH      operand A
//   b             in   WIDTH      operand B
//   equal         out  1          1 when last sampled a == b
//   out_valid     out  1          equal/diff_mask hold a fresh result this cycle
//   diff_mask     out  WIDTH      last sampled a ^ b (1 = bit differs)
//   mismatch_cnt  out  CNT_WIDTH  number of sampled pairs with a != b, saturating
//
// BEHAVIOUR
//   - Interface: one clock and an asynchronous, active-low reset.
//   - Reset (rst_n=0, async assert, sync-safe deassert):
//     - equal=0, out_valid=0, diff_mask=0, mismatch_cnt=0.
//     - Reset has effect immediately, without waiting for clk, even
//       mid-operation; any in-flight result is discarded.
//   - Latency: exactly 1 cycle.
//     - If in_valid=1 at edge N, then from edge N onward:
//       - equal = (a == b)
//       - diff_mask = a ^ b
//       - out_valid = 1
//   - in_valid=0 at an edge:
//     - out_valid=0.
//     - equal and diff_mask hold their previous values (no X, no clear).
//     - mismatch_cnt is unchanged.
//   - Comparison is full-width and unsigned. equal is the NOR-reduction of
//     diff_mask; no partial-width or signed interpretation.
//   - mismatch_cnt:
//     - Increments by 1 on each sampled pair with a != b.
//     - Saturates at 2^CNT_WIDTH-1 and never wraps.
//     - Cleared only by reset.
//   - Back-to-back valid pairs are accepted every cycle; there is no
//     backpressure.
//   - All outputs are driven directly from flops; there is no combinational
//     path from inputs to outputs.
//   - Inputs are only sampled when in_valid=1. X on a/b while in_valid=0 must
//     not propagate to any output.
//
// TESTING
//   1. a=4'b1010, b=4'b1010, in_valid=1
//      -> next edge: equal=1, diff_mask=0000, out_valid=1, cnt unchanged
//   2. a=4'b1001, b=4'b1010, in_valid=1
//      -> equal=0, diff_mask=0011, mismatch_cnt +1
//   3. a=4'b1111, b=4'b1111, then a=4'b0000, b=4'b1111 on consecutive cycles
//      -> equal 1 then 0, diff_mask 0000 then 1111, out_valid held 1
//   4. in_valid=0 with a/b toggling
//      -> out_valid=0, equal/diff_mask/cnt frozen at last values
//   5. Assert rst_n=0 between clock edges mid-stream
//      -> all outputs 0 immediately
//      -> after release, first valid pair produces correct result one edge later
//   6. CNT_WIDTH=2, apply 5 mismatching pairs
//      -> mismatch_cnt counts 1,2,3,3,3 (saturates, no wrap)

Source files
------------

// File: rtl/equal_comparator_four.sv
// equal_comparator_four
// Registered equality comparator. A qualified operand pair is compared and the
// result (equal flag, per-bit mismatch mask) is presented one edge later,
// alongside a saturating count of mismatching pairs seen since reset.
// Every output comes straight from a flop; operands are only looked at when
// in_valid is high, so unknown operands on idle cycles never reach the outputs.
module equal_comparator_four #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 equal,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     diff_mask,
    output logic [CNT_WIDTH-1:0] mismatch_cnt
);

    // All-ones value: the counter parks here instead of wrapping.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     w_diff;
    logic                 w_equal;
    logic                 w_cnt_inc;

    logic                 r_equal;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_diff_mask;
    logic [CNT_WIDTH-1:0] r_mismatch_cnt;

    // Per-bit mismatch: one XOR per operand bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit_diff
            assign w_diff[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // Operands are equal exactly when no bit differs (full-width, unsigned).
    assign w_equal = ~|w_diff;

    // Count a mismatching pair only while the counter still has headroom.
    assign w_cnt_inc = in_valid && !w_equal && (r_mismatch_cnt != CNT_MAX);

    // Result registers: refreshed on a valid pair, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_equal     <= 1'b0;
            r_diff_mask <= '0;
        end else if (in_valid) begin
            r_equal     <= w_equal;
            r_diff_mask <= w_diff;
        end
    end

    // Freshness flag: high for exactly the cycle after each valid pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
        end
    end

    // Saturating mismatch counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
        end
    end

    assign equal        = r_equal;
    assign out_valid    = r_out_valid;
    assign diff_mask    = r_diff_mask;
    assign mismatch_cnt = r_mismatch_cnt;

endmodule

// File: tb/tb_equal_comparator_four.sv
// tb_equal_comparator_four
// Directed and random stimulus against a behavioural model. Two instances share
// the stimulus: the default 8-bit counter and a 2-bit counter for saturation.
module tb_equal_comparator_four;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         equal8, valid8;
    logic [W-1:0] mask8;
    logic [7:0]   cnt8;
    logic         equal2, valid2;
    logic [W-1:0] mask2;
    logic [1:0]   cnt2;

    equal_comparator_four #(.WIDTH(W), .CNT_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .equal(equal8), .out_valid(valid8), .diff_mask(mask8), .mismatch_cnt(cnt8)
    );

    equal_comparator_four #(.WIDTH(W), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .equal(equal2), .out_valid(valid2), .diff_mask(mask2), .mismatch_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: last accepted pair plus total mismatches since reset.
    bit         m_valid;
    bit         m_equal;
    logic [W-1:0] m_mask;
    int         m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sat8, sat2;
        sat8 = (m_mis > 255) ? 255 : m_mis;
        sat2 = (m_mis > 3) ? 3 : m_mis;
        check({tag, ".valid"},  32'(valid8), 32'(m_valid));
        check({tag, ".equal"},  32'(equal8), 32'(m_equal));
        check({tag, ".mask"},   32'(mask8),  32'(m_mask));
        check({tag, ".cnt8"},   32'(cnt8),   32'(sat8));
        check({tag, ".valid2"}, 32'(valid2), 32'(m_valid));
        check({tag, ".equal2"}, 32'(equal2), 32'(m_equal));
        check({tag, ".mask2"},  32'(mask2),  32'(m_mask));
        check({tag, ".cnt2"},   32'(cnt2),   32'(sat2));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_equal = 1'b0;
        m_mask  = '0;
        m_mis   = 0;
    endtask

    // One transaction: drive at negedge, sample 1 ns after the rising edge.
    task automatic step(input string tag, input bit v, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb_v;
        @(posedge clk);
        #1;
        m_valid = v;
        if (v) begin
            m_equal = (ta == tb_v);
            m_mask  = ta ^ tb_v;
            if (ta != tb_v) m_mis++;
        end
        $display("[%0t] %s v=%0b a=%b b=%b -> equal=%b valid=%b mask=%b cnt8=%0d cnt2=%0d",
                 $time, tag, v, ta, tb_v, equal8, valid8, mask8, cnt8, cnt2);
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        $display("[%0t] %s async reset asserted", $time, tag);
        check_all(tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        model_reset();

        // Power-on reset, checked before any rising edge.
        #1 rst_n = 1'b0;
        #1;
        $display("[%0t] reset state", $time);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        step("t1_equal",    1'b1, 4'b1010, 4'b1010);
        step("t2_diff",     1'b1, 4'b1001, 4'b1010);
        step("t3_eq_ff",    1'b1, 4'b1111, 4'b1111);
        step("t3_ne_0f",    1'b1, 4'b0000, 4'b1111);
        step("t4_idle_a",   1'b0, 4'b0101, 4'b1010);
        step("t4_idle_b",   1'b0, 4'b1100, 4'b0011);
        step("t4_idle_x",   1'b0, 4'bxxxx, 4'bxx01);
        step("t4_resume",   1'b1, 4'b0110, 4'b0110);

        // Reset mid-stream, then first pair after release.
        step("t5_pre",      1'b1, 4'b0001, 4'b1000);
        mid_reset("t5_reset");
        step("t5_post",     1'b1, 4'b0111, 4'b0101);
        step("t5_post_eq",  1'b1, 4'b0011, 4'b0011);

        // Saturation of the 2-bit counter: 1,2,3,3,3.
        mid_reset("t6_reset");
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] ra;
            ra = 4'($urandom_range(0, 15));
            step("t6_sat", 1'b1, ra, ra ^ 4'($urandom_range(1, 15)));
        end

        // Random traffic, long enough to saturate the 8-bit counter.
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] ra, rb;
            bit           rv;
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 4) != 0);
            step("rand", rv, ra, rb);
        end

        // Mid-stream reset after saturation, then recovery.
        mid_reset("t7_reset");
        step("t7_post", 1'b1, 4'b1110, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
